mult_seq_ctrl: RTL

Sequential radix-4 unsigned multiplier controller. Accepts a multiplicand/multiplier pair on a start pulse and retires two multiplier bits per cycle through one shared row of two-bit multiplier cells (q0/q1 against mk/mk1). It shifts the partial product and raises a one-cycle done strobe. Sits between the operand source and the two-bit cell array; it owns operand registers, iteration count and handshake.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_step_row.sv | 35 +++
 rtl/mult_seq_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int STEPS         = DEFAULT_WIDTH / 2;

   // Two multiplier bits are retired per step.
   function automatic int steps_for(input int width);
      return width / 2;
   endfunction

   function automatic bit width_ok(input int width);
      return (width >= 4) && ((width % 2) == 0);
   endfunction

endpackage

// File: rtl/mult_step_row.sv
// One row of two-bit multiplier cells: s = hi + q0*m + q1*(m<<1), WIDTH+2 bits.
module mult_step_row #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] m_i,
   input  logic [1:0]       q_i,
   output logic [WIDTH+1:0] s_o
);

   logic [WIDTH:0] mk;
   logic [WIDTH:0] mk1;
   logic [WIDTH:0] hb;
   logic [1:0]     cy;
   logic [2:0]     tot;

   assign mk  = {1'b0, m_i} & {(WIDTH+1){q_i[0]}};
   assign mk1 = {m_i, 1'b0} & {(WIDTH+1){q_i[1]}};
   assign hb  = {1'b0, hi_i};

   // Each cell adds three one-bit terms plus a carry of up to 2, so the
   // carry never exceeds 2 and the final carry-out is a single bit.
   always_comb begin
      cy  = 2'b00;
      tot = 3'b000;
      s_o = '0;
      for (int j = 0; j <= WIDTH; j++) begin
         tot    = {2'b00, mk[j]} + {2'b00, mk1[j]} + {2'b00, hb[j]} + {1'b0, cy};
         s_o[j] = tot[0];
         cy     = tot[2:1];
      end
      s_o[WIDTH+1] = cy[0];
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential radix-4 unsigned multiplier controller: operand capture, step count
// and start/busy/done handshake around a shared row of two-bit cells.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [1:0]         dbg_state_o
);

   localparam int NSTEPS = steps_for(WIDTH);
   localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NSTEPS - 1);

   if (!width_ok(WIDTH)) begin : g_width_check
      $error("mult_seq_ctrl: WIDTH must be even and at least 4");
   end

   // Handshake: start is sampled only in IDLE; busy is high for every step
   // cycle; done is a one-cycle strobe after the last step, never with busy.
   state_t           state_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [CNT_W-1:0] count_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH+1:0] step_d;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;

   mult_step_row #(.WIDTH(WIDTH)) u_row (
      .hi_i (hi_q),
      .m_i  (m_q),
      .q_i  (lo_q[1:0]),
      .s_o  (step_d)
   );

   // The two low sum bits are final product bits and shift into lo as the
   // consumed multiplier bits leave it.
   assign hi_d = step_d[WIDTH+1:2];
   assign lo_d = {step_d[1:0], lo_q[WIDTH-1:2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= multiplicand;
                  lo_q    <= multiplier;
                  hi_q    <= '0;
                  count_q <= CNT_INIT;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               hi_q <= hi_d;
               lo_q <= lo_d;
               if (count_q == '0) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign product     = {hi_q, lo_q};
   assign dbg_state_o = state_q;

   a_busy_done_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(busy_q && done_q));

endmodule
